// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//   MEM-stage load/store engine sitting between the EX/MEM and MEM/WB pipeline
//   registers. It runs one req/gnt/rvalid transaction per memory instruction,
//   forms byte enables, replicates store data onto the byte lanes and
//   sign/zero-extends returned load data. Non-memory ops pass through with no
//   stall. MEM/WB is expected to capture when stall_mem_o is low.
//
//   Optional build macro: MISALIGN_TRAP_EN
//     defined   : misaligned H/HU/SH (a[0]=1) and W/SW (a[1:0]!=0) issue no
//                 request, raise misalign_o for the cycle and suppress
//                 reg_write_o.
//     undefined : misalign_o is 0; halfwords use a[1], words align down.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   flush_i             kill the op currently in MEM
//   valid_i             EX/MEM holds a live instruction
//   mem_read_i/write_i  load / store
//   funct3_i            size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU)
//   alu_res_i           effective address / ALU result
//   store_data_i        rs2 value for stores
//   rd_i, reg_write_i, wb_sel_mem_i   write-back controls (passed on)
//   mem_rdata_o         extended load data (valid in WAIT with rvalid)
//   alu_res_o, rd_o, reg_write_o, wb_sel_mem_o  write-back controls out
//   stall_mem_o         hold EX/MEM and earlier, disable MEM/WB
//   dmem_*              data-memory request/response bus
//   misalign_o          misaligned access detected
// -----------------------------------------------------------------------------
module mem_access_unit #(
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush_i,
    input  logic          valid_i,
    input  logic          mem_read_i,
    input  logic          mem_write_i,
    input  logic [2:0]    funct3_i,
    input  logic [31:0]   alu_res_i,
    input  logic [31:0]   store_data_i,
    input  logic [4:0]    rd_i,
    input  logic          reg_write_i,
    input  logic          wb_sel_mem_i,
    output logic [31:0]   mem_rdata_o,
    output logic [31:0]   alu_res_o,
    output logic [4:0]    rd_o,
    output logic          reg_write_o,
    output logic          wb_sel_mem_o,
    output logic          stall_mem_o,
    output logic          dmem_req_o,
    output logic          dmem_we_o,
    output logic [AW-1:0] dmem_addr_o,
    output logic [3:0]    dmem_be_o,
    output logic [31:0]   dmem_wdata_o,
    input  logic          dmem_gnt_i,
    input  logic          dmem_rvalid_i,
    input  logic [31:0]   dmem_rdata_i,
    output logic          misalign_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_WAIT  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t        state_r;
    state_t        state_nxt_s;
    logic          mem_op_s;
    logic          misalign_s;
    logic          start_s;
    logic          stall_s;
    logic [31:0]   rdata_s;

    logic          req_r;
    logic          we_r;
    logic [3:0]    be_r;
    logic [AW-1:0] addr_r;
    logic [31:0]   wdata_r;
    logic [2:0]    f3_r;
    logic [1:0]    alo_r;

    // Byte enables for an access of the given size at byte offset a.
    function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] a);
        logic [3:0] be;
        case (f3[1:0])
            2'b00:   be = 4'b0001 << a;
            2'b01:   be = a[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicate store data so every lane carries the right byte/half.
    function automatic logic [31:0] lane_wdata(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] w;
        case (f3[1:0])
            2'b00:   w = {4{d[7:0]}};
            2'b01:   w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

    // Pick the addressed byte/half out of the word and extend it.
    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] a,
                                                input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = 8'(w >> {a, 3'b000});
        h = a[1] ? w[31:16] : w[15:0];
        case (f3[1:0])
            2'b00:   r = f3[2] ? {24'd0, b} : {{24{b[7]}}, b};
            2'b01:   r = f3[2] ? {16'd0, h} : {{16{h[15]}}, h};
            default: r = w;
        endcase
        return r;
    endfunction

    assign mem_op_s = valid_i & (mem_read_i | mem_write_i) & ~flush_i;

`ifdef MISALIGN_TRAP_EN
    // Misalignment only matters when a new op is about to be launched from IDLE.
    always_comb begin
        misalign_s = 1'b0;
        if (mem_op_s && (state_r == S_IDLE)) begin
            case (funct3_i[1:0])
                2'b00:   misalign_s = 1'b0;
                2'b01:   misalign_s = alu_res_i[0];
                default: misalign_s = (alu_res_i[1:0] != 2'b00);
            endcase
        end else begin
            misalign_s = 1'b0;
        end
    end
`else
    assign misalign_s = 1'b0;
`endif

    // Next-state, stall and load-data decode.
    always_comb begin
        state_nxt_s = state_r;
        stall_s     = 1'b0;
        rdata_s     = 32'd0;
        start_s     = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (mem_op_s && !misalign_s) begin
                    start_s     = 1'b1;
                    stall_s     = 1'b1;
                    state_nxt_s = S_REQ;
                end else begin
                    stall_s     = 1'b0;
                end
            end
            S_REQ: begin
                stall_s = 1'b1;
                // A grant commits the transaction even if flush arrives with it.
                if (dmem_gnt_i) begin
                    if (we_r) begin
                        stall_s     = 1'b0;
                        state_nxt_s = S_IDLE;
                    end else if (flush_i) begin
                        state_nxt_s = S_DRAIN;
                    end else begin
                        state_nxt_s = S_WAIT;
                    end
                end else if (flush_i) begin
                    state_nxt_s = S_IDLE;
                end else begin
                    state_nxt_s = S_REQ;
                end
            end
            S_WAIT: begin
                stall_s = ~dmem_rvalid_i;
                if (dmem_rvalid_i) begin
                    rdata_s     = load_extend(f3_r, alo_r, dmem_rdata_i);
                    state_nxt_s = S_IDLE;
                end else if (flush_i) begin
                    state_nxt_s = S_DRAIN;
                end else begin
                    state_nxt_s = S_WAIT;
                end
            end
            S_DRAIN: begin
                // The outstanding beat belongs to a killed load; only hold the
                // pipe if a new memory op is waiting to start.
                stall_s = mem_op_s;
                if (dmem_rvalid_i) begin
                    state_nxt_s = S_IDLE;
                end else begin
                    state_nxt_s = S_DRAIN;
                end
            end
            default: begin
                stall_s     = 1'b0;
                state_nxt_s = S_IDLE;
            end
        endcase
    end

    // State register and latched bus payload, held stable until granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
            req_r   <= 1'b0;
            we_r    <= 1'b0;
            be_r    <= 4'd0;
            addr_r  <= '0;
            wdata_r <= 32'd0;
            f3_r    <= 3'd0;
            alo_r   <= 2'd0;
        end else begin
            state_r <= state_nxt_s;
            if (start_s) begin
                req_r   <= 1'b1;
                we_r    <= mem_write_i;
                be_r    <= lane_be(funct3_i, alu_res_i[1:0]);
                addr_r  <= {alu_res_i[AW-1:2], 2'b00};
                wdata_r <= lane_wdata(funct3_i, store_data_i);
                f3_r    <= funct3_i;
                alo_r   <= alu_res_i[1:0];
            end else if ((state_r == S_REQ) && (dmem_gnt_i || flush_i)) begin
                req_r   <= 1'b0;
            end
        end
    end

    assign dmem_req_o   = req_r;
    assign dmem_we_o    = we_r;
    assign dmem_be_o    = be_r;
    assign dmem_addr_o  = addr_r;
    assign dmem_wdata_o = wdata_r;

    assign stall_mem_o  = stall_s;
    assign mem_rdata_o  = rdata_s;
    assign misalign_o   = misalign_s;
    assign alu_res_o    = alu_res_i;
    assign rd_o         = rd_i;
    assign wb_sel_mem_o = wb_sel_mem_i;
    assign reg_write_o  = reg_write_i & valid_i & ~misalign_s;

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
//   Self-checking bench: directed vector table, hand-written flush/pass-through
//   sequences and randomized loads/stores compared against a byte-arithmetic
//   reference model.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush_i, valid_i, mem_read_i, mem_write_i;
    logic [2:0]  funct3_i;
    logic [31:0] alu_res_i, store_data_i;
    logic [4:0]  rd_i;
    logic        reg_write_i, wb_sel_mem_i;
    logic [31:0] mem_rdata_o, alu_res_o;
    logic [4:0]  rd_o;
    logic        reg_write_o, wb_sel_mem_o, stall_mem_o;
    logic        dmem_req_o, dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_gnt_i, dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;
    logic        misalign_o;

    int checks   = 0;
    int failures = 0;

    mem_access_unit #(.AW(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .valid_i(valid_i),
        .mem_read_i(mem_read_i), .mem_write_i(mem_write_i), .funct3_i(funct3_i),
        .alu_res_i(alu_res_i), .store_data_i(store_data_i), .rd_i(rd_i),
        .reg_write_i(reg_write_i), .wb_sel_mem_i(wb_sel_mem_i),
        .mem_rdata_o(mem_rdata_o), .alu_res_o(alu_res_o), .rd_o(rd_o),
        .reg_write_o(reg_write_o), .wb_sel_mem_o(wb_sel_mem_o),
        .stall_mem_o(stall_mem_o), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
        .dmem_addr_o(dmem_addr_o), .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
        .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i),
        .dmem_rdata_i(dmem_rdata_i), .misalign_o(misalign_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] rword;
        int          gd;
        int          rvd;
        logic [3:0]  ebe;
        logic [31:0] ewd;
        logic [31:0] erd;
    } vec_t;

    // ---------------- reference model (byte arithmetic) ----------------
    function automatic int m_nbytes(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic int m_off(input logic [2:0] f3, input logic [31:0] a);
        int nb = m_nbytes(f3);
        return (int'(a[1:0]) / nb) * nb;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
        int v = ((1 << m_nbytes(f3)) - 1) << m_off(f3, a);
        return 4'(v);
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] r;
        int nb = m_nbytes(f3);
        r = 32'd0;
        for (int k = 0; k < 4; k++) r[8*k +: 8] = d[8*(k % nb) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] w);
        int nb = m_nbytes(f3);
        logic [31:0] v, mask;
        v = w >> (8 * m_off(f3, a));
        if (nb == 4) return v;
        mask = (32'd1 << (8 * nb)) - 32'd1;
        v = v & mask;
        if (!f3[2] && v[8*nb-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic m_misaligned(input logic [2:0] f3, input logic [31:0] a);
`ifdef MISALIGN_TRAP_EN
        return (int'(a[1:0]) % m_nbytes(f3)) != 0;
`else
        return 1'b0;
`endif
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic go_idle();
        valid_i = 1'b0; mem_read_i = 1'b0; mem_write_i = 1'b0;
        reg_write_i = 1'b0; wb_sel_mem_i = 1'b0; flush_i = 1'b0;
        dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
    endtask

    // Runs one memory op, entered and left at posedge+1, holding the EX/MEM
    // inputs while stalled like the pipeline would.
    task automatic run_op(input vec_t v, input string nm);
        valid_i = 1'b1; mem_read_i = !v.st; mem_write_i = v.st; funct3_i = v.f3;
        alu_res_i = v.addr; store_data_i = v.data; rd_i = 5'd7;
        reg_write_i = !v.st; wb_sel_mem_i = !v.st; flush_i = 1'b0;
        dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
        #1;
        if (m_misaligned(v.f3, v.addr)) begin
            chk({nm, "_mis"}, 32'(misalign_o), 32'd1);
            chk({nm, "_mis_stall"}, 32'(stall_mem_o), 32'd0);
            chk({nm, "_mis_rw"}, 32'(reg_write_o), 32'd0);
            @(posedge clk); #1;
            chk({nm, "_mis_noreq"}, 32'(dmem_req_o), 32'd0);
            go_idle();
            return;
        end
        chk({nm, "_stall_idle"}, 32'(stall_mem_o), 32'd1);
        chk({nm, "_nomis"}, 32'(misalign_o), 32'd0);
        @(posedge clk); #1;
        for (int i = 0; i < v.gd; i++) begin
            chk({nm, "_req_wait"}, 32'(dmem_req_o), 32'd1);
            chk({nm, "_be_wait"}, 32'(dmem_be_o), 32'(v.ebe));
            chk({nm, "_stall_wait"}, 32'(stall_mem_o), 32'd1);
            @(posedge clk); #1;
        end
        chk({nm, "_req"}, 32'(dmem_req_o), 32'd1);
        chk({nm, "_we"}, 32'(dmem_we_o), 32'(v.st));
        chk({nm, "_addr"}, dmem_addr_o, v.addr & 32'hFFFF_FFFC);
        chk({nm, "_be"}, 32'(dmem_be_o), 32'(v.ebe));
        if (v.st) chk({nm, "_wdata"}, dmem_wdata_o, v.ewd);
        dmem_gnt_i = 1'b1;
        #1;
        chk({nm, "_stall_gnt"}, 32'(stall_mem_o), 32'(!v.st));
        @(posedge clk); #1;
        dmem_gnt_i = 1'b0;
        chk({nm, "_req_drop"}, 32'(dmem_req_o), 32'd0);
        if (!v.st) begin
            for (int i = 0; i < v.rvd; i++) begin
                chk({nm, "_stall_rv"}, 32'(stall_mem_o), 32'd1);
                chk({nm, "_rdata_idle"}, mem_rdata_o, 32'd0);
                @(posedge clk); #1;
            end
            dmem_rvalid_i = 1'b1; dmem_rdata_i = v.rword;
            #1;
            chk({nm, "_stall_done"}, 32'(stall_mem_o), 32'd0);
            chk({nm, "_rdata"}, mem_rdata_o, v.erd);
            chk({nm, "_rw"}, 32'(reg_write_o), 32'd1);
            @(posedge clk); #1;
            dmem_rvalid_i = 1'b0;
        end
        go_idle();
    endtask

    vec_t tbl[11];
    logic [2:0] ld_f3[7];
    logic [2:0] st_f3[3];

    initial begin
        vec_t v;
        rst_n = 1'b0; go_idle();
        funct3_i = 3'd0; alu_res_i = 32'd0; store_data_i = 32'd0; rd_i = 5'd0;
        dmem_rdata_i = 32'd0;

        //          st    f3    addr         data          rword         gd rvd be       wdata          rdata
        tbl[0]  = '{1'b0, 3'd2, 32'h100, 32'h0,        32'hDEADBEEF, 0, 0, 4'b1111, 32'h0,        32'hDEADBEEF};
        tbl[1]  = '{1'b0, 3'd0, 32'h103, 32'h0,        32'h80123456, 1, 2, 4'b1000, 32'h0,        32'hFFFFFF80};
        tbl[2]  = '{1'b0, 3'd4, 32'h103, 32'h0,        32'h80123456, 0, 1, 4'b1000, 32'h0,        32'h00000080};
        tbl[3]  = '{1'b0, 3'd5, 32'h102, 32'h0,        32'hABCD1234, 2, 0, 4'b1100, 32'h0,        32'h0000ABCD};
        tbl[4]  = '{1'b0, 3'd1, 32'h100, 32'h0,        32'h1234F00D, 0, 3, 4'b0011, 32'h0,        32'hFFFFF00D};
        tbl[5]  = '{1'b1, 3'd0, 32'h101, 32'h5A,       32'h0,        3, 0, 4'b0010, 32'h5A5A5A5A, 32'h0};
        tbl[6]  = '{1'b1, 3'd1, 32'h102, 32'h0000BEEF, 32'h0,        1, 0, 4'b1100, 32'hBEEFBEEF, 32'h0};
        tbl[7]  = '{1'b1, 3'd2, 32'h200, 32'hCAFEF00D, 32'h0,        0, 0, 4'b1111, 32'hCAFEF00D, 32'h0};
        tbl[8]  = '{1'b0, 3'd2, 32'h102, 32'h0,        32'h11223344, 0, 0, 4'b1111, 32'h0,        32'h11223344};
        tbl[9]  = '{1'b0, 3'd3, 32'h010, 32'h0,        32'h76543210, 0, 1, 4'b1111, 32'h0,        32'h76543210};
        tbl[10] = '{1'b0, 3'd0, 32'h102, 32'h0,        32'h007F0000, 0, 0, 4'b0100, 32'h0,        32'h0000007F};
        ld_f3 = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
        st_f3 = '{3'd0, 3'd1, 3'd2};

        // Reset state
        #12;
        chk("rst_req", 32'(dmem_req_o), 32'd0);
        chk("rst_we", 32'(dmem_we_o), 32'd0);
        chk("rst_be", 32'(dmem_be_o), 32'd0);
        chk("rst_addr", dmem_addr_o, 32'd0);
        chk("rst_wdata", dmem_wdata_o, 32'd0);
        chk("rst_stall", 32'(stall_mem_o), 32'd0);
        chk("rst_rdata", mem_rdata_o, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed table
        for (int i = 0; i < 11; i++) run_op(tbl[i], $sformatf("vec%0d", i));

        // ADD: non-memory op passes straight through
        valid_i = 1'b1; alu_res_i = 32'h1234_5678; rd_i = 5'd9; reg_write_i = 1'b1;
        #1;
        chk("add_stall", 32'(stall_mem_o), 32'd0);
        chk("add_alu", alu_res_o, 32'h1234_5678);
        chk("add_rd", 32'(rd_o), 32'd9);
        chk("add_rw", 32'(reg_write_o), 32'd1);
        @(posedge clk); #1;
        chk("add_noreq", 32'(dmem_req_o), 32'd0);
        go_idle();

        // LW, flush in WAIT -> DRAIN swallows the beat, next LW is clean
        v = tbl[0];
        valid_i = 1'b1; mem_read_i = 1'b1; funct3_i = 3'd2; alu_res_i = 32'h100;
        reg_write_i = 1'b1; wb_sel_mem_i = 1'b1;
        @(posedge clk); #1;
        dmem_gnt_i = 1'b1;
        @(posedge clk); #1;
        dmem_gnt_i = 1'b0; flush_i = 1'b1;
        #1;
        chk("fl_wait_stall", 32'(stall_mem_o), 32'd1);
        chk("fl_wait_rdata", mem_rdata_o, 32'd0);
        @(posedge clk); #1;
        go_idle();
        #1;
        chk("drain_stall_idle", 32'(stall_mem_o), 32'd0);
        chk("drain_rw", 32'(reg_write_o), 32'd0);
        @(posedge clk); #1;
        valid_i = 1'b1; mem_read_i = 1'b1; funct3_i = 3'd2; alu_res_i = 32'h100;
        reg_write_i = 1'b1; wb_sel_mem_i = 1'b1;
        dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h0BAD_0BAD;
        #1;
        chk("drain_stall_memop", 32'(stall_mem_o), 32'd1);
        chk("drain_rdata", mem_rdata_o, 32'd0);
        chk("drain_noreq", 32'(dmem_req_o), 32'd0);
        @(posedge clk); #1;
        dmem_rvalid_i = 1'b0;
        run_op(v, "post_drain");

        // Flush in REQ before grant: request drops, back to IDLE
        valid_i = 1'b1; mem_write_i = 1'b1; funct3_i = 3'd2; alu_res_i = 32'h300;
        store_data_i = 32'h1;
        @(posedge clk); #1;
        flush_i = 1'b1;
        #1;
        chk("fl_req_stall", 32'(stall_mem_o), 32'd1);
        @(posedge clk); #1;
        go_idle();
        #1;
        chk("fl_req_drop", 32'(dmem_req_o), 32'd0);
        chk("fl_req_idle", 32'(stall_mem_o), 32'd0);

        // Flush together with grant on a load: grant wins, beat drained
        valid_i = 1'b1; mem_read_i = 1'b1; funct3_i = 3'd2; alu_res_i = 32'h400;
        @(posedge clk); #1;
        dmem_gnt_i = 1'b1; flush_i = 1'b1;
        @(posedge clk); #1;
        go_idle();
        dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hFFFF_FFFF;
        #1;
        chk("flgnt_rdata", mem_rdata_o, 32'd0);
        chk("flgnt_stall", 32'(stall_mem_o), 32'd0);
        @(posedge clk); #1;
        dmem_rvalid_i = 1'b0;
        run_op(tbl[2], "post_flgnt");

        // Randomized ops against the model
        for (int n = 0; n < 40; n++) begin
            v.st    = 1'($urandom_range(0, 1));
            v.f3    = v.st ? st_f3[$urandom_range(0, 2)] : ld_f3[$urandom_range(0, 6)];
            v.addr  = $urandom;
            v.data  = $urandom;
            v.rword = $urandom;
            v.gd    = $urandom_range(0, 3);
            v.rvd   = $urandom_range(0, 3);
            v.ebe   = m_be(v.f3, v.addr);
            v.ewd   = m_wdata(v.f3, v.data);
            v.erd   = m_load(v.f3, v.addr, v.rword);
            run_op(v, $sformatf("rnd%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
